// File: rtl/frm_reg_slice.sv
// Two-entry skid buffer on the frame interface: registers val/data/rdy in both
// directions, counts frames leaving the slice and flags framing errors.
module frm_reg_slice #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_frm_val,
    output logic                  in_frm_rdy,
    input  logic [DATA_WIDTH-1:0] in_frm_data,
    input  logic                  in_frm_sof,
    input  logic                  in_frm_eof,
    input  logic                  in_frm_sol,
    input  logic                  in_frm_eol,
    output logic                  out_frm_val,
    input  logic                  out_frm_rdy,
    output logic [DATA_WIDTH-1:0] out_frm_data,
    output logic                  out_frm_sof,
    output logic                  out_frm_eof,
    output logic                  out_frm_sol,
    output logic                  out_frm_eol,
    output logic [CNT_WIDTH-1:0]  frm_cnt,
    input  logic                  err_clr,
    output logic                  err_flag
);

    localparam int PW = DATA_WIDTH + 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         main_q, main_d;
    logic [PW-1:0]         skid_q, skid_d;
    logic                  out_val_q, out_val_d;
    logic                  in_rdy_q, in_rdy_d;
    logic                  in_frame_q, in_frame_d;
    logic                  err_q, err_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  in_xfer;
    logic                  out_xfer;
    logic [PW-1:0]         in_pay;
    logic                  main_sof;
    logic                  main_eof;
    logic                  err_set;

    // Payload packing: {data, sof, eof, sol, eol}; markers always travel with their pixel.
    assign in_pay   = {in_frm_data, in_frm_sof, in_frm_eof, in_frm_sol, in_frm_eol};
    assign main_sof = main_q[3];
    assign main_eof = main_q[2];

    assign in_xfer  = in_frm_val & in_rdy_q;
    assign out_xfer = out_val_q & out_frm_rdy;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_d  = in_pay;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_d = in_pay;
                end else if (in_xfer) begin
                    skid_d  = in_pay;
                    state_d = FULL;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Handshake outputs are registered copies of the next state, so neither
        // in_frm_rdy nor out_frm_val has a combinational path through the slice.
        out_val_d = (state_d != EMPTY);
        in_rdy_d  = (state_d != FULL);
    end

    always_comb begin
        in_frame_d = in_frame_q;
        cnt_d      = cnt_q;
        err_set    = 1'b0;
        if (out_xfer) begin
            err_set = (main_sof & in_frame_q) | (~main_sof & ~in_frame_q);
            if (main_eof) begin
                in_frame_d = 1'b0;
                cnt_d      = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else if (main_sof) begin
                in_frame_d = 1'b1;
            end
        end
        // A new error outranks a simultaneous clear.
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            out_val_q  <= 1'b0;
            in_rdy_q   <= 1'b1;
            in_frame_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            out_val_q  <= out_val_d;
            in_rdy_q   <= in_rdy_d;
            in_frame_q <= in_frame_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_frm_rdy   = in_rdy_q;
    assign out_frm_val  = out_val_q;
    assign out_frm_data = main_q[PW-1:4];
    assign out_frm_sof  = main_q[3];
    assign out_frm_eof  = main_q[2];
    assign out_frm_sol  = main_q[1];
    assign out_frm_eol  = main_q[0];
    assign frm_cnt      = cnt_q;
    assign err_flag     = err_q;

endmodule
